// File: rtl/alu_pkg.sv
// Shared encodings for the accumulator ALU: op codes, FSM states and the
// bit positions of the packed result-flag register.
package alu_pkg;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_NOT  = 3'b001;
   localparam logic [2:0] OP_OR   = 3'b010;
   localparam logic [2:0] OP_XOR  = 3'b011;
   localparam logic [2:0] OP_SHL  = 3'b100;
   localparam logic [2:0] OP_SUM  = 3'b101;
   localparam logic [2:0] OP_SUB  = 3'b110;
   localparam logic [2:0] OP_TWOS = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 3;
   localparam int NFLAGS = 4;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU for every op except SHL; SHL passes A through with
// carry/ovf cleared, which is exactly the shamt==0 result.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [2:0]       op_i,
   output logic [WIDTH-1:0] y_o,
   output logic             carry_o,
   output logic             ovf_o
);

   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH:0] sum_w;
   logic [WIDTH:0] sub_w;

   // One extra bit holds the carry-out; for SUB it is the no-borrow flag.
   assign sum_w = {1'b0, a_i} + {1'b0, b_i};
   assign sub_w = {1'b0, a_i} + {1'b0, ~b_i} + (WIDTH+1)'(1);

   always_comb begin
      y_o     = a_i;
      carry_o = 1'b0;
      ovf_o   = 1'b0;
      case (op_i)
         OP_AND: y_o = a_i & b_i;
         OP_NOT: y_o = ~a_i;
         OP_OR:  y_o = a_i | b_i;
         OP_XOR: y_o = a_i ^ b_i;
         OP_SUM: begin
            y_o     = sum_w[WIDTH-1:0];
            carry_o = sum_w[WIDTH];
            ovf_o   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_w[WIDTH-1] != a_i[WIDTH-1]);
         end
         OP_SUB: begin
            y_o     = sub_w[WIDTH-1:0];
            carry_o = sub_w[WIDTH];
            ovf_o   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (sub_w[WIDTH-1] != a_i[WIDTH-1]);
         end
         OP_TWOS: begin
            y_o     = ~a_i + WIDTH'(1);
            carry_o = (a_i == '0);
            ovf_o   = (a_i == MIN_NEG);
         end
         default: y_o = a_i;
      endcase
   end

endmodule

// File: rtl/alu_acc_seq.sv
// Two-accumulator sequential ALU: op/result valid-ready handshakes, a serial
// one-bit-per-cycle left shifter and registered result flags.
module alu_acc_seq
   import alu_pkg::*;
#(
   parameter int  WIDTH     = 4,
   parameter bit  WRITEBACK = 1'b1,
   localparam int SW        = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ld_a,
   input  logic             ld_b,
   input  logic [WIDTH-1:0] ld_data,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [2:0]       op,
   input  logic [SW-1:0]    shamt,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res,
   output logic             carry,
   output logic             zero,
   output logic             neg,
   output logic             ovf,
   output logic [WIDTH-1:0] acc_a,
   output logic [WIDTH-1:0] acc_b
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; op_ready is high only in IDLE and res_valid only in RESP, and
   // the result/flags hold stable in RESP until res_ready is seen.

   state_t              state_q;
   logic [WIDTH-1:0]    a_q, b_q, res_q, sh_q;
   logic [SW-1:0]       cnt_q;
   logic [NFLAGS-1:0]   flags_q;

   logic [WIDTH-1:0]    core_y, sh_d;
   logic                core_c, core_v;
   logic                op_fire;

   assign op_fire = op_valid && (state_q == S_IDLE);
   assign sh_d    = {sh_q[WIDTH-2:0], 1'b0};

   alu_core #(.WIDTH(WIDTH)) u_core (
      .a_i     (a_q),
      .b_i     (b_q),
      .op_i    (op),
      .y_o     (core_y),
      .carry_o (core_c),
      .ovf_o   (core_v)
   );

   function automatic logic [NFLAGS-1:0] mk_flags(input logic c, input logic v,
                                                  input logic [WIDTH-1:0] y);
      logic [NFLAGS-1:0] f;
      f         = '0;
      f[FLAG_C] = c;
      f[FLAG_Z] = (y == '0);
      f[FLAG_N] = y[WIDTH-1];
      f[FLAG_V] = v;
      return f;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sh_q    <= '0;
         cnt_q   <= '0;
         flags_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (op_fire) begin
                  if (op == OP_SHL && shamt != '0) begin
                     sh_q    <= a_q;
                     cnt_q   <= shamt;
                     state_q <= S_SHIFT;
                  end else begin
                     res_q   <= core_y;
                     flags_q <= mk_flags(core_c, core_v, core_y);
                     if (WRITEBACK) a_q <= core_y;
                     state_q <= S_RESP;
                  end
               end else begin
                  if (ld_a) a_q <= ld_data;
                  if (ld_b) b_q <= ld_data;
               end
            end
            // The shift runs on sh_q so A keeps its value until the result lands.
            S_SHIFT: begin
               sh_q  <= sh_d;
               cnt_q <= cnt_q - SW'(1);
               if (cnt_q == SW'(1)) begin
                  res_q   <= sh_d;
                  flags_q <= mk_flags(sh_q[WIDTH-1], 1'b0, sh_d);
                  if (WRITEBACK) a_q <= sh_d;
                  state_q <= S_RESP;
               end
            end
            S_RESP: begin
               if (res_ready) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign op_ready  = (state_q == S_IDLE);
   assign res_valid = (state_q == S_RESP);
   assign res       = res_q;
   assign carry     = flags_q[FLAG_C];
   assign zero      = flags_q[FLAG_Z];
   assign neg       = flags_q[FLAG_N];
   assign ovf       = flags_q[FLAG_V];
   assign acc_a     = a_q;
   assign acc_b     = b_q;

endmodule

// File: tb/tb_alu_acc_seq.sv
// Directed bench for alu_acc_seq: a 4-bit instance for the op set, latency and
// backpressure, and an 8-bit instance for mid-shift reset and load/op collision.
module tb_alu_acc_seq;
   import alu_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset4, ld_a4, ld_b4, op_valid4, op_ready4, res_valid4, res_ready4;
   logic [3:0] ld_data4, res4, acc_a4, acc_b4;
   logic [2:0] op4;
   logic [1:0] shamt4;
   logic       carry4, zero4, neg4, ovf4;

   logic       reset8, ld_a8, ld_b8, op_valid8, op_ready8, res_valid8, res_ready8;
   logic [7:0] ld_data8, res8, acc_a8, acc_b8;
   logic [2:0] op8;
   logic [2:0] shamt8;
   logic       carry8, zero8, neg8, ovf8;

   int checks = 0;
   int errors = 0;

   alu_acc_seq #(.WIDTH(4), .WRITEBACK(1'b1)) u_dut4 (
      .clk(clk), .reset(reset4), .ld_a(ld_a4), .ld_b(ld_b4), .ld_data(ld_data4),
      .op_valid(op_valid4), .op_ready(op_ready4), .op(op4), .shamt(shamt4),
      .res_valid(res_valid4), .res_ready(res_ready4), .res(res4), .carry(carry4),
      .zero(zero4), .neg(neg4), .ovf(ovf4), .acc_a(acc_a4), .acc_b(acc_b4)
   );

   alu_acc_seq #(.WIDTH(8), .WRITEBACK(1'b1)) u_dut8 (
      .clk(clk), .reset(reset8), .ld_a(ld_a8), .ld_b(ld_b8), .ld_data(ld_data8),
      .op_valid(op_valid8), .op_ready(op_ready8), .op(op8), .shamt(shamt8),
      .res_valid(res_valid8), .res_ready(res_ready8), .res(res8), .carry(carry8),
      .zero(zero8), .neg(neg8), .ovf(ovf8), .acc_a(acc_a8), .acc_b(acc_b8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load4(input logic [3:0] a, input logic [3:0] b);
      ld_a4 = 1'b1; ld_data4 = a; tick();
      ld_a4 = 1'b0; ld_b4 = 1'b1; ld_data4 = b; tick();
      ld_b4 = 1'b0;
   endtask

   // Fires one op, scrambles op/shamt afterwards, and checks res_valid rises
   // exactly lat cycles after the fire cycle while A holds a_hold meanwhile.
   task automatic fire4(input logic [2:0] o, input logic [1:0] sh, input int lat,
                        input logic [3:0] a_hold);
      check("op_ready_before_fire", op_ready4, 1);
      op4 = o; shamt4 = sh; op_valid4 = 1'b1;
      tick();
      op_valid4 = 1'b0;
      op4 = 3'($urandom_range(0, 7));
      shamt4 = 2'($urandom_range(0, 3));
      for (int i = 1; i < lat; i++) begin
         check("res_valid_early", res_valid4, 0);
         check("acc_a_during_shift", acc_a4, a_hold);
         tick();
      end
      check("res_valid_on_time", res_valid4, 1);
   endtask

   task automatic chk4(input string tag, input logic [3:0] r, input logic c,
                       input logic z, input logic n, input logic v);
      check({tag, ".res"}, res4, r);
      check({tag, ".carry"}, carry4, c);
      check({tag, ".zero"}, zero4, z);
      check({tag, ".neg"}, neg4, n);
      check({tag, ".ovf"}, ovf4, v);
      check({tag, ".acc_a"}, acc_a4, r);
      tick();
   endtask

   initial begin
      reset4 = 1'b1; ld_a4 = 1'b0; ld_b4 = 1'b0; ld_data4 = '0; op_valid4 = 1'b0;
      op4 = '0; shamt4 = '0; res_ready4 = 1'b1;
      reset8 = 1'b1; ld_a8 = 1'b0; ld_b8 = 1'b0; ld_data8 = '0; op_valid8 = 1'b0;
      op8 = '0; shamt8 = '0; res_ready8 = 1'b1;
      repeat (2) tick();

      check("rst.res", res4, 0);
      check("rst.flags", {carry4, zero4, neg4, ovf4}, 0);
      check("rst.res_valid", res_valid4, 0);
      check("rst.op_ready", op_ready4, 1);
      check("rst.acc", {acc_a4, acc_b4}, 0);
      reset4 = 1'b0;
      reset8 = 1'b0;

      // SUM with carry out, no signed overflow, written back into A
      load4(4'b0111, 4'b1110);
      check("load.acc_a", acc_a4, 4'b0111);
      check("load.acc_b", acc_b4, 4'b1110);
      fire4(OP_SUM, 2'd0, 1, 4'b0111);
      chk4("sum", 4'b0101, 1, 0, 0, 0);

      load4(4'b1111, 4'b0001);
      fire4(OP_SUM, 2'd0, 1, 4'b1111);
      chk4("sum_wrap", 4'b0000, 1, 1, 0, 0);

      load4(4'b0011, 4'b0101);
      fire4(OP_SUB, 2'd0, 1, 4'b0011);
      chk4("sub_borrow", 4'b1110, 0, 0, 1, 0);

      load4(4'b1000, 4'b0001);
      fire4(OP_SUB, 2'd0, 1, 4'b1000);
      chk4("sub_ovf", 4'b0111, 1, 0, 0, 1);

      // 0111 << 1 = 1110 (out 0), << 1 = 1100 (out 1)
      load4(4'b0111, 4'b0000);
      fire4(OP_SHL, 2'd2, 3, 4'b0111);
      chk4("shl2", 4'b1100, 1, 0, 1, 0);

      load4(4'b0111, 4'b0000);
      fire4(OP_SHL, 2'd0, 1, 4'b0111);
      chk4("shl0", 4'b0111, 0, 0, 0, 0);

      load4(4'b1000, 4'b0000);
      fire4(OP_TWOS, 2'd0, 1, 4'b1000);
      chk4("twos_min", 4'b1000, 0, 0, 1, 1);

      load4(4'b0000, 4'b0000);
      fire4(OP_TWOS, 2'd0, 1, 4'b0000);
      chk4("twos_zero", 4'b0000, 1, 1, 0, 0);

      load4(4'b0101, 4'b0000);
      fire4(OP_NOT, 2'd0, 1, 4'b0101);
      chk4("not", 4'b1010, 0, 0, 1, 0);

      load4(4'b1100, 4'b1010);
      fire4(OP_AND, 2'd0, 1, 4'b1100);
      chk4("and", 4'b1000, 0, 0, 1, 0);
      load4(4'b1100, 4'b1010);
      fire4(OP_OR, 2'd0, 1, 4'b1100);
      chk4("or", 4'b1110, 0, 0, 1, 0);
      load4(4'b1100, 4'b1010);
      fire4(OP_XOR, 2'd0, 1, 4'b1100);
      chk4("xor", 4'b0110, 0, 0, 0, 0);

      // Backpressure: result held, no accept, ld_a ignored while in RESP
      load4(4'b0001, 4'b0001);
      res_ready4 = 1'b0;
      fire4(OP_SUM, 2'd0, 1, 4'b0001);
      op4 = OP_SUM; op_valid4 = 1'b1; ld_a4 = 1'b1; ld_data4 = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         check("bp.res", res4, 4'b0010);
         check("bp.flags", {carry4, zero4, neg4, ovf4}, 4'b0000);
         check("bp.res_valid", res_valid4, 1);
         check("bp.op_ready", op_ready4, 0);
         check("bp.acc_a", acc_a4, 4'b0010);
         tick();
      end
      op_valid4 = 1'b0; ld_a4 = 1'b0; res_ready4 = 1'b1;
      tick();
      check("bp_release.op_ready", op_ready4, 1);
      check("bp_release.res_valid", res_valid4, 0);
      check("bp_release.acc_a", acc_a4, 4'b0010);
      fire4(OP_SUM, 2'd0, 1, 4'b0010);
      chk4("after_bp", 4'b0011, 0, 0, 0, 0);

      // 8-bit: 0x40 + 0x40 overflows into the sign bit
      ld_a8 = 1'b1; ld_data8 = 8'h40; tick();
      ld_a8 = 1'b0; ld_b8 = 1'b1; tick();
      ld_b8 = 1'b0;
      op8 = OP_SUM; op_valid8 = 1'b1; tick();
      op_valid8 = 1'b0;
      check("w8_sum.res", res8, 8'h80);
      check("w8_sum.flags", {carry8, zero8, neg8, ovf8}, 4'b0011);
      tick();

      // Reset during the 3rd SHIFT cycle aborts everything
      ld_a8 = 1'b1; ld_data8 = 8'hB5; tick();
      ld_a8 = 1'b0;
      op8 = OP_SHL; shamt8 = 3'd7; op_valid8 = 1'b1; tick();
      op_valid8 = 1'b0;
      check("w8_shift.res_valid", res_valid8, 0);
      check("w8_shift.op_ready", op_ready8, 0);
      check("w8_shift.acc_a", acc_a8, 8'hB5);
      tick();
      tick();
      reset8 = 1'b1;
      tick();
      check("w8_rst.res", res8, 0);
      check("w8_rst.flags", {carry8, zero8, neg8, ovf8}, 0);
      check("w8_rst.res_valid", res_valid8, 0);
      check("w8_rst.op_ready", op_ready8, 1);
      check("w8_rst.acc", {acc_a8, acc_b8}, 0);
      reset8 = 1'b0;
      tick();
      check("w8_post_rst.res_valid", res_valid8, 0);
      check("w8_post_rst.op_ready", op_ready8, 1);

      // ld_a coinciding with op_fire: op sees old A, load is dropped
      ld_a8 = 1'b1; ld_data8 = 8'h12; tick();
      ld_a8 = 1'b0; ld_b8 = 1'b1; ld_data8 = 8'h03; tick();
      ld_b8 = 1'b0;
      op8 = OP_SUM; op_valid8 = 1'b1; ld_a8 = 1'b1; ld_data8 = 8'h55; tick();
      op_valid8 = 1'b0; ld_a8 = 1'b0;
      check("w8_collide.res", res8, 8'h15);
      check("w8_collide.res_valid", res_valid8, 1);
      check("w8_collide.acc_a", acc_a8, 8'h15);
      check("w8_collide.acc_b", acc_b8, 8'h03);
      tick();
      check("w8_collide_after.acc_a", acc_a8, 8'h15);
      check("w8_collide_after.op_ready", op_ready8, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
